// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand forwarding and load-use hazard logic.
// Holds the mux-select encoding, the per-stage tracking record, and the zero-register index.
package fwd_pkg;

    localparam int REG_BITS = 5;
    localparam logic [REG_BITS-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } stage_rec_t;

endpackage

// File: rtl/fwd_compare.sv
// Chooses the forwarding source for one ID-stage source operand.
// It compares the operand against the in-flight EX and MEM producers.
module fwd_compare
    import fwd_pkg::*;
#(
    parameter logic [REG_BITS-1:0] XZR = ZERO_REG
) (
    input  logic [REG_BITS-1:0] src_i,
    input  stage_rec_t          ex_i,
    input  stage_rec_t          mem_i,
    output fwd_sel_t            sel_o
);

    logic ex_hit;
    logic mem_hit;

    // A load still in EX has no data yet; the stall logic handles that case.
    assign ex_hit  = ex_i.valid & ex_i.reg_write & ~ex_i.mem_read &
                     (ex_i.rd != XZR) & (ex_i.rd == src_i);
    assign mem_hit = mem_i.valid & mem_i.reg_write &
                     (mem_i.rd != XZR) & (mem_i.rd == src_i);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit) begin
            sel_o = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

    always_comb begin
        assert (ex_i.valid || !(ex_i.reg_write || ex_i.mem_read));
        assert (mem_i.valid || !(mem_i.reg_write || mem_i.mem_read));
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control.
// It runs beside the ID/EX register and tracks the EX/MEM/WB destinations.
module fwd_hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          ex_fwd_a,
    output logic [1:0]          ex_fwd_b
);

    import fwd_pkg::*;

    localparam logic [REG_BITS-1:0] XZR = REG_BITS'(ZERO_REG);

    stage_rec_t ex_q, ex_d, mem_q, wb_q;
    fwd_sel_t   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    fwd_sel_t   sel_a, sel_b;
    logic       advance;

    assign stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != XZR) &
                   ((id_rn == ex_q.rd) | (id_rm == ex_q.rd));

    // Flush and stall both turn the ID slot into a bubble; stall is still reported on flush.
    assign advance = id_valid & ~flush & ~stall;

    fwd_compare #(.XZR(XZR)) u_cmp_a (
        .src_i (id_rn),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .sel_o (sel_a)
    );

    fwd_compare #(.XZR(XZR)) u_cmp_b (
        .src_i (id_rm),
        .ex_i  (ex_q),
        .mem_i (mem_q),
        .sel_o (sel_b)
    );

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (advance) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            fwd_a_d        = sel_a;
            fwd_b_d        = sel_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ex_fwd_a = fwd_a_q;
    assign ex_fwd_b = fwd_b_q;

    // The WB record needs no forwarding (RF writes on the falling edge); kept for debug only.
    always_comb begin
        assert (wb_q.valid || !(wb_q.reg_write || wb_q.mem_read));
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: the driver queues hand-computed expectations per ID cycle.
// The monitor compares them on the falling edge against stall and the EX selects.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       id_reg_write, id_mem_read, flush;
    logic       stall;
    logic [1:0] ex_fwd_a, ex_fwd_b;

    typedef struct {
        string      nm;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    fwd_hazard_ctrl #(.REG_BITS(5), .ZERO_REG(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .ex_fwd_a     (ex_fwd_a),
        .ex_fwd_b     (ex_fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ID fields are applied just after a rising edge. On the next falling edge, stall reflects
    // those fields, and ex_fwd_* reflect the instruction that was in ID one cycle earlier.
    task automatic step(input string nm, input bit v, input int rn, input int rm, input int rd,
                        input bit rw, input bit mr, input bit fl,
                        input bit est, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        @(posedge clk);
        #2;
        id_valid     = v;
        id_rn        = 5'(rn);
        id_rm        = 5'(rm);
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        e.nm = nm; e.a = ea; e.b = eb; e.st = est;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [1:0] ea, input logic [1:0] eb);
        step(nm, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.nm, ".stall"}, int'(stall), int'(e.st));
                check({e.nm, ".fwd_a"}, int'(ex_fwd_a), int'(e.a));
                check({e.nm, ".fwd_b"}, int'(ex_fwd_b), int'(e.b));
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1;
        id_valid = 1'b1; id_rn = 5'd1; id_rm = 5'd1; id_rd = 5'd1;
        id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
        #12;
        check("reset.stall", int'(stall), 0);
        check("reset.fwd_a", int'(ex_fwd_a), 0);
        check("reset.fwd_b", int'(ex_fwd_b), 0);
        @(negedge clk);
        reset = 1'b0;
        id_valid = 1'b0;

        idle("start", 2'b00, 2'b00);

        // Back-to-back ALU dependency on operand A
        step("t1.add1",  1,  2, 3,  1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t1.add4",  1,  1, 5,  4, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t1.ex",                                  2'b01, 2'b00);

        // Producer two ahead on operand B
        step("t2.add1",  1,  2, 3,  1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t2.add11", 1, 12, 13, 11, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t2.sub",   1,  7, 1,  6, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t2.ex",                                  2'b00, 2'b10);

        // Two producers of X1: nearest wins
        step("t3.add1a", 1,  2, 3,  1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t3.add1b", 1,  2, 3,  1, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t3.add8",  1,  1, 1,  8, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t3.ex",                                  2'b01, 2'b01);

        // Load-use: one stall cycle, bubble, then retried ADD gets 10
        step("t4.ldur",  1,  2, 0,  9, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t4.use",   1,  9, 2, 10, 1, 0, 0, 1, 2'b00, 2'b00);
        step("t4.retry", 1,  9, 2, 10, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t4.ex",                                  2'b10, 2'b00);

        // XZR is never a forwarding source nor a stall cause
        step("t5.wzr",   1,  2, 3, 31, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t5.rzr",   1, 31, 31, 4, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t5.ex",                                  2'b00, 2'b00);
        step("t5.ldzr",  1,  2, 0, 31, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t5.rzr2",  1, 31, 31, 4, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t5.ex2",                                 2'b00, 2'b00);

        // Flush together with a load-use match: stall reported, bubble, no repeat stall
        step("t6.ldur",  1,  2, 0,  9, 1, 1, 0, 0, 2'b00, 2'b00);
        step("t6.flush", 1,  9, 2, 10, 1, 0, 1, 1, 2'b00, 2'b00);
        step("t6.next",  1,  9, 9, 12, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t6.ex",                                  2'b10, 2'b10);

        // Asynchronous reset with a hazard pair in flight
        step("t7.add9",  1,  2, 3,  9, 1, 0, 0, 0, 2'b00, 2'b00);
        step("t7.ldur",  1,  9, 0, 10, 1, 1, 0, 0, 2'b00, 2'b00);
        @(posedge clk);
        #2;
        id_valid = 1'b1; id_rn = 5'd10; id_rm = 5'd10; id_rd = 5'd11;
        id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
        #1;
        check("t7.pre.stall", int'(stall), 1);
        check("t7.pre.fwd_a", int'(ex_fwd_a), 1);
        check("t7.pre.fwd_b", int'(ex_fwd_b), 0);
        reset = 1'b1;
        #1;
        check("t7.rst.stall", int'(stall), 0);
        check("t7.rst.fwd_a", int'(ex_fwd_a), 0);
        check("t7.rst.fwd_b", int'(ex_fwd_b), 0);
        @(negedge clk);
        reset = 1'b0;
        id_valid = 1'b0;
        step("t7.after", 1, 10, 9,  4, 1, 0, 0, 0, 2'b00, 2'b00);
        idle("t7.ex",                                  2'b00, 2'b00);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
